tcm_arbiter: RTL and testbench
==============================

# tcm_arbiter

- Shares the SoC's single-port 4 KB tightly-coupled RAM between two requesters:
  - the FemtoRV32 memory port, whose strobes are already gated by the RAM address decode;
  - the video line-fetch engine.
- Arbitration is per cycle. Video has priority, and a starvation bound guarantees the CPU a slot.
- CPU conflicts become `mem_rbusy`/`mem_wbusy` stalls.
- Sits between `FemtoRV32`, the video fetch unit and the RAM array inside `soc_demo`.

## Interface
Parameters:
- `ADDR_W`, 10, RAM word-address width.
- `VID_MAX_RUN`, 4, maximum consecutive video grants while the CPU waits; range 1–15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  32  byte address; word index is `cpu_addr[ADDR_W+1:2]`.
- `cpu_wdata`  in  32  write data.
- `cpu_wmask`  in  4  byte write mask; non-zero for one cycle = write strobe.
- `cpu_rstrb`  in  1  one-cycle read strobe.
- `cpu_rdata`  out  32  read data to CPU.
- `cpu_rbusy`  out  1  read pending.
- `cpu_wbusy`  out  1  write pending.
- `vid_req`  in  1  level request from the fetch engine.
- `vid_addr`  in  ADDR_W  video word address.
- `vid_gnt`  out  1  combinational grant, same cycle.
- `vid_rdata`  out  32  video read data.
- `vid_rvalid`  out  1  `vid_rdata` valid.
- `ram_en`  out  1  RAM access this cycle.
- `ram_we`  out  4  byte write enables.
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  synchronous read data, valid one cycle after `ram_en`.

## Operation
Registered state:
- `pend_rd`, `pend_wr`: latched CPU request.
- `lat_addr`, `lat_wdata`, `lat_mask`: CPU request fields.
- `cpu_ret`, `vid_ret`: data-return flags.
- `run`: 4-bit counter.
- `cpu_rdata_q`: held CPU read data.

CPU candidate (`cpu_c`):
- Set when `cpu_rstrb`, `|cpu_wmask`, `pend_rd` or `pend_wr` is high.
- Fields come from the inputs on a strobe cycle, from the latches otherwise.

Grant decision each cycle:
- Only `cpu_c` → `GNT_CPU`.
- Only `vid_req` → `GNT_VID`.
- Both → `GNT_VID` if `run < VID_MAX_RUN`, else `GNT_CPU`.
- Neither → `GNT_NONE`, and `ram_en` = 0.

Effects of each grant:
- **`GNT_CPU`**:
  - drives `ram_en`, `ram_addr`, and `ram_we` = mask for writes / 0 for reads;
  - clears `pend_*`;
  - a read sets `cpu_ret` for the next cycle;
  - `run` ← 0.
- **`GNT_VID`**:
  - `vid_gnt` = 1, `ram_we` = 0, `ram_addr` = `vid_addr`;
  - `vid_ret` is set for the next cycle;
  - if `cpu_c`, `run` ← `run + 1`, saturating at `VID_MAX_RUN`; else `run` ← 0.
- **CPU strobe not granted**: latch the request into `pend_rd`/`pend_wr` and the `lat_*` registers.

Outputs:
- `cpu_rbusy` = `pend_rd`; `cpu_wbusy` = `pend_wr` (pure registers).
- `cpu_rdata` = `cpu_ret ? ram_rdata : cpu_rdata_q`. `cpu_rdata_q` captures `ram_rdata` when `cpu_ret` = 1.
- `vid_rvalid` = `vid_ret`. `vid_rdata` = `ram_rdata` when `vid_ret` = 1; it holds its last value otherwise.

Illegal cases (bench asserts, RTL behaviour undefined):
- `cpu_rstrb` and `|cpu_wmask` in the same cycle.
- A new CPU strobe while `pend_*` = 1.

## Timing
- Reset values:
  - `cpu_rdata` = 32'h00000013 (NOP);
  - `cpu_rbusy` = `cpu_wbusy` = 0;
  - `vid_gnt` = `vid_rvalid` = 0;
  - `vid_rdata` = 0;
  - `ram_en` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_wdata` = 0;
  - `run` = 0.
- Reset forces `ram_en` = 0 while asserted.
- Uncontended CPU read:
  - strobe at T → RAM access at T → `cpu_rdata` valid at T+1;
  - `cpu_rbusy` never rises (zero-wait).
- Contended CPU read:
  - strobe at T, granted at T+k → `cpu_rbusy` high T+1..T+k, low at T+k+1 with data valid.
- Contended CPU write: `cpu_wbusy` high T+1..T+k; the RAM write happens at T+k.
- Starvation bound: k ≤ `VID_MAX_RUN`.
- Video: `vid_gnt` at T → `vid_rvalid` at T+1. The fetch engine advances `vid_addr` on `vid_gnt`.
- Reset mid-operation: pending requests and return flags are dropped asynchronously; no RAM write occurs after reset asserts.

## Structure
- Package `tcm_arb_pkg`:
  - enum `gnt_t` {`GNT_NONE`, `GNT_CPU`, `GNT_VID`};
  - constant `RV_NOP` = 32'h00000013.
- One sub-module, `arb_run_counter`: saturating contention counter with clear, inc and limit-compare output.
- Grant muxing and latches live in the top level.

## Test plan
- Idle video, CPU read of word 5 (RAM = 32'hDEADBEEF) → `ram_en` same cycle, `cpu_rdata` = DEADBEEF next cycle, `cpu_rbusy` never 1.
- `vid_req` held high, CPU read strobe at T, `VID_MAX_RUN` = 4 → `vid_gnt` at T..T+3, CPU grant at T+4, `cpu_rbusy` high T+1..T+4, data at T+5.
- CPU write with mask 4'b0010 and data 32'h0000AB00 during video contention → `cpu_wbusy` high until the grant cycle; RAM byte 1 becomes AB, other bytes unchanged; the next video read of that word returns the new value.
- `vid_req` alone for 8 cycles with sequential addresses → 8 consecutive `vid_gnt`, `vid_rvalid` each following cycle with matching data, `run` stays 0.
- `reset` asserted while `pend_rd` = 1 → `cpu_rbusy` drops immediately, `cpu_rdata` = 32'h00000013, no `ram_en` until after deassert.
- Random strobes plus random `vid_req` over 10k cycles → no CPU wait exceeds 4 cycles, scoreboard matches the RAM model, no assertion fires.

Source files
------------

// File: rtl/tcm_arb_pkg.sv
// Shared types and constants for the tightly-coupled RAM arbiter.
package tcm_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_VID
    } gnt_t;

    localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/arb_run_counter.sv
// Saturating count of consecutive video grants taken while the CPU waits.
module arb_run_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    logic [3:0] run_q, run_d;

    assign at_limit_o = (run_q >= 4'(LIMIT));

    always_comb begin
        run_d = run_q;
        if (clr_i) begin
            run_d = '0;
        end else if (inc_i && !at_limit_o) begin
            run_d = run_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/tcm_arbiter.sv
// Per-cycle arbiter sharing the single-port TCM between the CPU and video fetch.
module tcm_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned VID_MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wmask,
    input  logic              cpu_rstrb,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rbusy,
    output logic              cpu_wbusy,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [31:0]       vid_rdata,
    output logic              vid_rvalid,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic              pend_rd_q, pend_rd_d;
    logic              pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [31:0]       lat_wdata_q, lat_wdata_d;
    logic [3:0]        lat_mask_q, lat_mask_d;
    logic              cpu_ret_q, cpu_ret_d;
    logic              vid_ret_q, vid_ret_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       vid_rdata_q, vid_rdata_d;

    logic              cpu_strobe;
    logic              cpu_c;
    logic              c_wr;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [3:0]        c_mask;
    logic              at_limit;
    gnt_t              gnt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    // A fresh strobe is served straight from the inputs; a waiting one from the latches.
    assign cpu_strobe = cpu_rstrb | (|cpu_wmask);
    assign cpu_c      = cpu_strobe | pend_rd_q | pend_wr_q;
    assign c_wr       = cpu_strobe ? (|cpu_wmask)              : pend_wr_q;
    assign c_addr     = cpu_strobe ? cpu_addr[ADDR_W+1:2]      : lat_addr_q;
    assign c_wdata    = cpu_strobe ? cpu_wdata                 : lat_wdata_q;
    assign c_mask     = cpu_strobe ? cpu_wmask                 : lat_mask_q;

    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (vid_req && (!cpu_c || !at_limit)) begin
                gnt = GNT_VID;
            end else if (cpu_c) begin
                gnt = GNT_CPU;
            end
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        vid_gnt   = 1'b0;
        case (gnt)
            GNT_CPU: begin
                ram_en    = 1'b1;
                ram_addr  = c_addr;
                ram_we    = c_wr ? c_mask : 4'b0000;
                ram_wdata = c_wdata;
            end
            GNT_VID: begin
                ram_en   = 1'b1;
                vid_gnt  = 1'b1;
                ram_addr = vid_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_rd_d   = pend_rd_q;
        pend_wr_d   = pend_wr_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_mask_d  = lat_mask_q;
        if (gnt == GNT_CPU) begin
            pend_rd_d = 1'b0;
            pend_wr_d = 1'b0;
        end else if (cpu_strobe) begin
            pend_rd_d   = cpu_rstrb;
            pend_wr_d   = |cpu_wmask;
            lat_addr_d  = cpu_addr[ADDR_W+1:2];
            lat_wdata_d = cpu_wdata;
            lat_mask_d  = cpu_wmask;
        end
        cpu_ret_d   = (gnt == GNT_CPU) && !c_wr;
        vid_ret_d   = (gnt == GNT_VID);
        cpu_rdata_d = cpu_ret_q ? ram_rdata : cpu_rdata_q;
        vid_rdata_d = vid_ret_q ? ram_rdata : vid_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_rd_q   <= 1'b0;
            pend_wr_q   <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_mask_q  <= '0;
            cpu_ret_q   <= 1'b0;
            vid_ret_q   <= 1'b0;
            cpu_rdata_q <= RV_NOP;
            vid_rdata_q <= '0;
        end else begin
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_mask_q  <= lat_mask_d;
            cpu_ret_q   <= cpu_ret_d;
            vid_ret_q   <= vid_ret_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    // Run only accumulates while video wins over a waiting CPU.
    arb_run_counter #(
        .LIMIT(VID_MAX_RUN)
    ) u_run (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (!((gnt == GNT_VID) && cpu_c)),
        .inc_i      ((gnt == GNT_VID) && cpu_c),
        .at_limit_o (at_limit)
    );

    assign cpu_rbusy  = pend_rd_q;
    assign cpu_wbusy  = pend_wr_q;
    assign cpu_rdata  = cpu_ret_q ? ram_rdata : cpu_rdata_q;
    assign vid_rvalid = vid_ret_q;
    assign vid_rdata  = vid_ret_q ? ram_rdata : vid_rdata_q;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Scoreboard bench for tcm_arbiter with a behavioural single-port RAM.
module tb_tcm_arbiter;

    localparam int AW   = 10;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [3:0]    cpu_wmask = '0;
    logic          cpu_rstrb = 1'b0;
    logic [31:0]   cpu_rdata;
    logic          cpu_rbusy, cpu_wbusy;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_gnt;
    logic [31:0]   vid_rdata;
    logic          vid_rvalid;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    tcm_arbiter #(
        .ADDR_W      (AW),
        .VID_MAX_RUN (MAXR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wmask  (cpu_wmask),
        .cpu_rstrb  (cpu_rstrb),
        .cpu_rdata  (cpu_rdata),
        .cpu_rbusy  (cpu_rbusy),
        .cpu_wbusy  (cpu_wbusy),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rdata  (vid_rdata),
        .vid_rvalid (vid_rvalid),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(int i);
        return (i == 5) ? 32'hDEADBEEF : (32'h5A000000 ^ (i * 32'h00010203));
    endfunction

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic        preload = 1'b1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] cq [$];
    logic [31:0] vq [$];
    logic        out = 1'b0;
    logic        out_rd = 1'b0;
    int          wait_n = 0;
    logic        vret = 1'b0;
    logic        s_vg, s_en;
    logic [3:0]  s_we;
    logic [AW-1:0] s_addr;

    // Called at posedge+1 with this cycle's inputs already driven.
    task automatic tick();
        logic [AW-1:0] w;
        logic          busy;
        #1;
        assert (!(cpu_rstrb && (cpu_wmask != 4'b0)));
        assert (!((cpu_rstrb || (cpu_wmask != 4'b0)) && (cpu_rbusy || cpu_wbusy)));
        s_vg   = vid_gnt;
        s_en   = ram_en;
        s_we   = ram_we;
        s_addr = ram_addr;
        if (cpu_rstrb || (cpu_wmask != 4'b0)) begin
            w      = cpu_addr[AW+1:2];
            out    = 1'b1;
            out_rd = cpu_rstrb;
            wait_n = 0;
            if (cpu_rstrb) cq.push_back(ref_mem[w]);
            else
                for (int b = 0; b < 4; b++)
                    if (cpu_wmask[b]) ref_mem[w][b*8 +: 8] = cpu_wdata[b*8 +: 8];
        end
        vret = vid_gnt;
        if (vid_gnt) begin
            check("vid_gnt_addr", 32'(ram_addr), 32'(vid_addr));
            vq.push_back(ref_mem[vid_addr]);
        end
        @(posedge clk);
        #1;
        check("vid_rvalid", 32'(vid_rvalid), 32'(vret));
        if (vret && vq.size() > 0) check("vid_rdata", vid_rdata, vq.pop_front());
        if (out) begin
            wait_n++;
            busy = out_rd ? cpu_rbusy : cpu_wbusy;
            if (!busy) begin
                check("cpu_wait_ok", 32'(wait_n <= MAXR + 1), 32'd1);
                if (out_rd && cq.size() > 0) check("cpu_rdata", cpu_rdata, cq.pop_front());
                out = 1'b0;
            end else if (wait_n > MAXR + 1) begin
                check("cpu_wait_bound", 32'(wait_n), 32'(MAXR + 1));
                if (out_rd && cq.size() > 0) void'(cq.pop_front());
                out = 1'b0;
            end
        end
        if (s_vg) vid_addr = {1'b0, vid_addr[8:0] + 9'd1};
        cpu_rstrb = 1'b0;
        cpu_wmask = 4'b0;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp9;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_cpu_rdata", cpu_rdata, 32'h00000013);
        check("rst_busy", {30'b0, cpu_rbusy, cpu_wbusy}, 32'd0);
        check("rst_vid", {30'b0, vid_gnt, vid_rvalid}, 32'd0);
        check("rst_vid_rdata", vid_rdata, 32'd0);
        check("rst_ram_ctl", {27'b0, ram_en, ram_we}, 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        reset = 1'b0;

        // Uncontended read of word 5.
        cpu_rstrb = 1'b1;
        cpu_addr  = 32'd5 << 2;
        tick();
        check("t1_ram_en", {27'b0, s_en, s_we}, 32'h10);
        check("t1_ram_addr", 32'(s_addr), 32'd5);
        check("t1_rbusy", 32'(cpu_rbusy), 32'd0);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);

        // Video alone, sequential addresses.
        vid_req  = 1'b1;
        vid_addr = 10'd16;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_vid_gnt", 32'(s_vg), 32'd1);
            check("t4_vid_addr", 32'(s_addr), 32'(16 + i));
        end

        // Contended read: video wins MAXR cycles, then the CPU.
        cpu_rstrb = 1'b1;
        cpu_addr  = 32'd33 << 2;
        for (int i = 0; i < MAXR; i++) begin
            tick();
            check("t2_vid_gnt", 32'(s_vg), 32'd1);
            check("t2_rbusy", 32'(cpu_rbusy), 32'd1);
        end
        tick();
        check("t2_cpu_gnt", {26'b0, s_vg, s_en, s_we}, 32'h10);
        check("t2_cpu_addr", 32'(s_addr), 32'd33);
        check("t2_rbusy_done", 32'(cpu_rbusy), 32'd0);

        // Contended byte write to word 9.
        vid_addr  = 10'd100;
        exp9      = (ref_mem[9] & ~32'h0000FF00) | 32'h0000AB00;
        cpu_wmask = 4'b0010;
        cpu_wdata = 32'h0000AB00;
        cpu_addr  = 32'd9 << 2;
        for (int i = 0; i < MAXR; i++) begin
            tick();
            check("t3_vid_gnt", 32'(s_vg), 32'd1);
            check("t3_wbusy", 32'(cpu_wbusy), 32'd1);
        end
        tick();
        check("t3_cpu_we", {27'b0, s_en, s_we}, 32'h12);
        check("t3_wbusy_done", 32'(cpu_wbusy), 32'd0);
        check("t3_mem9", mem[9], exp9);
        vid_addr = 10'd9;
        tick();
        check("t3_vid_rd9", vid_rdata, exp9);

        // Reset while a read is pending.
        cpu_rstrb = 1'b1;
        cpu_addr  = 32'd7 << 2;
        tick();
        check("t5_rbusy_pre", 32'(cpu_rbusy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rbusy", 32'(cpu_rbusy), 32'd0);
        check("t5_rdata", cpu_rdata, 32'h00000013);
        check("t5_vid", {29'b0, vid_gnt, vid_rvalid, ram_en}, 32'd0);
        check("t5_vid_rdata", vid_rdata, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("t5_ram_en", 32'(ram_en), 32'd0);
        end
        reset  = 1'b0;
        out    = 1'b0;
        vret   = 1'b0;
        cq.delete();
        vq.delete();

        // Random traffic; CPU writes stay in the upper half, video reads the lower half.
        vid_addr = 10'd0;
        for (int c = 0; c < 10000; c++) begin
            vid_req = ($urandom_range(0, 3) != 0);
            if (!out && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    cpu_rstrb = 1'b1;
                    cpu_addr  = 32'($urandom_range(0, 1023)) << 2;
                end else begin
                    cpu_wmask = 4'($urandom_range(1, 15));
                    cpu_addr  = 32'($urandom_range(512, 1023)) << 2;
                    cpu_wdata = $urandom;
                end
            end
            tick();
        end
        vid_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 1024; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
